// File: rtl/mem_arbiter.sv
// Arbitrates one MMU memory port between inst reads, data reads and data writes.
// Optional response watchdog enabled by defining MEMARB_TIMEOUT_EN.
module mem_arbiter #(
   parameter int STARVE_LIMIT   = 4,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        I_RDEN,
   input  logic [31:0] I_RADDR,
   output logic        I_RVALID,
   output logic [31:0] I_ROADDR,
   output logic [31:0] I_RDATA,
   input  logic        D_RDEN,
   input  logic [31:0] D_RADDR,
   output logic        D_RVALID,
   output logic [31:0] D_ROADDR,
   output logic [31:0] D_RDATA,
   input  logic        D_WREN,
   input  logic [31:0] D_WADDR,
   input  logic [3:0]  D_WSTRB,
   input  logic [31:0] D_WDATA,
   output logic        D_WDONE,
   output logic        MEM_WAIT,
   output logic        M_REQ,
   output logic        M_WE,
   output logic [31:0] M_ADDR,
   output logic [3:0]  M_STRB,
   output logic [31:0] M_WDATA,
   input  logic        M_GNT,
   input  logic        M_RVALID,
   input  logic [31:0] M_RDATA,
   output logic        TIMEOUT_ERR
);

   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2} state_t;
   typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_I = 2'd1, OWN_D = 2'd2, OWN_W = 2'd3} owner_t;

   localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

   state_t      state;
   state_t      state_nxt;
   owner_t      owner;
   owner_t      owner_nxt;
   owner_t      winner;
   logic [7:0]  starve_cnt;
   logic        resp_timeout;
   logic        resp_end;
   logic [31:0] rdata_sel;

   logic        m_req_nxt;
   logic        m_we_nxt;
   logic [31:0] m_addr_nxt;
   logic [3:0]  m_strb_nxt;
   logic [31:0] m_wdata_nxt;
   logic        i_rvalid_nxt;
   logic [31:0] i_roaddr_nxt;
   logic [31:0] i_rdata_nxt;
   logic        d_rvalid_nxt;
   logic [31:0] d_roaddr_nxt;
   logic [31:0] d_rdata_nxt;
   logic        d_wdone_nxt;

`ifdef MEMARB_TIMEOUT_EN
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
   logic [7:0] wdog;

   assign resp_timeout = (state == RESP) && !M_RVALID && (wdog == TO_LAST);

   // Watchdog counts consecutive RESP cycles; any other state clears it
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         wdog        <= 8'd0;
         TIMEOUT_ERR <= 1'b0;
      end else begin
         if (state == RESP) begin
            wdog <= wdog + 8'd1;
         end else begin
            wdog <= 8'd0;
         end
         TIMEOUT_ERR <= resp_timeout;
      end
   end
`else
   logic [7:0] unused_timeout;

   assign unused_timeout = 8'(TIMEOUT_CYCLES);
   assign resp_timeout   = 1'b0;
   assign TIMEOUT_ERR    = 1'b0;
`endif

   assign resp_end  = M_RVALID || resp_timeout;
   assign rdata_sel = M_RVALID ? M_RDATA : 32'h0000_0000;

   assign MEM_WAIT = (state != IDLE) ||
                     (I_RDEN && D_RDEN) || (I_RDEN && D_WREN) || (D_RDEN && D_WREN);

   // Fixed priority pick, overridden once fetch has been starved long enough
   always_comb begin
      winner = OWN_NONE;
      if (I_RDEN && (starve_cnt == LIMIT)) begin
         winner = OWN_I;
      end else if (D_WREN) begin
         winner = OWN_W;
      end else if (D_RDEN) begin
         winner = OWN_D;
      end else if (I_RDEN) begin
         winner = OWN_I;
      end else begin
         winner = OWN_NONE;
      end
   end

   // State register
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (winner != OWN_NONE) begin
               state_nxt = REQ;
            end else begin
               state_nxt = IDLE;
            end
         end
         REQ: begin
            if (M_GNT) begin
               state_nxt = (owner == OWN_W) ? IDLE : RESP;
            end else begin
               state_nxt = REQ;
            end
         end
         RESP: begin
            if (resp_end) begin
               state_nxt = IDLE;
            end else begin
               state_nxt = RESP;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Output logic: next values for every registered output
   always_comb begin
      owner_nxt    = owner;
      m_req_nxt    = M_REQ;
      m_we_nxt     = M_WE;
      m_addr_nxt   = M_ADDR;
      m_strb_nxt   = M_STRB;
      m_wdata_nxt  = M_WDATA;
      i_rvalid_nxt = 1'b0;
      i_roaddr_nxt = I_ROADDR;
      i_rdata_nxt  = I_RDATA;
      d_rvalid_nxt = 1'b0;
      d_roaddr_nxt = D_ROADDR;
      d_rdata_nxt  = D_RDATA;
      d_wdone_nxt  = 1'b0;
      case (state)
         IDLE: begin
            if (winner != OWN_NONE) begin
               owner_nxt = winner;
               m_req_nxt = 1'b1;
               case (winner)
                  OWN_W: begin
                     m_we_nxt    = 1'b1;
                     m_addr_nxt  = D_WADDR;
                     m_strb_nxt  = D_WSTRB;
                     m_wdata_nxt = D_WDATA;
                  end
                  OWN_D: begin
                     m_we_nxt    = 1'b0;
                     m_addr_nxt  = D_RADDR;
                     m_strb_nxt  = 4'hF;
                     m_wdata_nxt = 32'h0000_0000;
                  end
                  OWN_I: begin
                     m_we_nxt    = 1'b0;
                     m_addr_nxt  = I_RADDR;
                     m_strb_nxt  = 4'hF;
                     m_wdata_nxt = 32'h0000_0000;
                  end
                  default: m_req_nxt = 1'b0;
               endcase
            end else begin
               m_req_nxt = 1'b0;
            end
         end
         REQ: begin
            if (M_GNT) begin
               m_req_nxt   = 1'b0;
               d_wdone_nxt = (owner == OWN_W);
            end else begin
               m_req_nxt = 1'b1;
            end
         end
         RESP: begin
            // A timed-out response is reported to the owner with zero data
            if (resp_end) begin
               if (owner == OWN_I) begin
                  i_rvalid_nxt = 1'b1;
                  i_roaddr_nxt = M_ADDR;
                  i_rdata_nxt  = rdata_sel;
               end else if (owner == OWN_D) begin
                  d_rvalid_nxt = 1'b1;
                  d_roaddr_nxt = M_ADDR;
                  d_rdata_nxt  = rdata_sel;
               end else begin
                  d_rvalid_nxt = 1'b0;
               end
            end else begin
               m_req_nxt = 1'b0;
            end
         end
         default: m_req_nxt = 1'b0;
      endcase
   end

   // Registered outputs and latched transaction context
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         owner    <= OWN_NONE;
         M_REQ    <= 1'b0;
         M_WE     <= 1'b0;
         M_ADDR   <= 32'h0000_0000;
         M_STRB   <= 4'h0;
         M_WDATA  <= 32'h0000_0000;
         I_RVALID <= 1'b0;
         I_ROADDR <= 32'h0000_0000;
         I_RDATA  <= 32'h0000_0000;
         D_RVALID <= 1'b0;
         D_ROADDR <= 32'h0000_0000;
         D_RDATA  <= 32'h0000_0000;
         D_WDONE  <= 1'b0;
      end else begin
         owner    <= owner_nxt;
         M_REQ    <= m_req_nxt;
         M_WE     <= m_we_nxt;
         M_ADDR   <= m_addr_nxt;
         M_STRB   <= m_strb_nxt;
         M_WDATA  <= m_wdata_nxt;
         I_RVALID <= i_rvalid_nxt;
         I_ROADDR <= i_roaddr_nxt;
         I_RDATA  <= i_rdata_nxt;
         D_RVALID <= d_rvalid_nxt;
         D_ROADDR <= d_roaddr_nxt;
         D_RDATA  <= d_rdata_nxt;
         D_WDONE  <= d_wdone_nxt;
      end
   end

   // Starve counter: data wins while fetch waits, saturating at the limit
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         starve_cnt <= 8'd0;
      end else if (!I_RDEN) begin
         starve_cnt <= 8'd0;
      end else if ((state == IDLE) && (winner == OWN_I)) begin
         starve_cnt <= 8'd0;
      end else if ((state == IDLE) && ((winner == OWN_D) || (winner == OWN_W)) &&
                   (starve_cnt < LIMIT)) begin
         starve_cnt <= starve_cnt + 8'd1;
      end else begin
         starve_cnt <= starve_cnt;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (STARVE_LIMIT=2, TIMEOUT_CYCLES=8).
module tb_mem_arbiter;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic        I_RDEN = 1'b0;
   logic [31:0] I_RADDR = 32'h0;
   logic        I_RVALID;
   logic [31:0] I_ROADDR;
   logic [31:0] I_RDATA;
   logic        D_RDEN = 1'b0;
   logic [31:0] D_RADDR = 32'h0;
   logic        D_RVALID;
   logic [31:0] D_ROADDR;
   logic [31:0] D_RDATA;
   logic        D_WREN = 1'b0;
   logic [31:0] D_WADDR = 32'h0;
   logic [3:0]  D_WSTRB = 4'h0;
   logic [31:0] D_WDATA = 32'h0;
   logic        D_WDONE;
   logic        MEM_WAIT;
   logic        M_REQ;
   logic        M_WE;
   logic [31:0] M_ADDR;
   logic [3:0]  M_STRB;
   logic [31:0] M_WDATA;
   logic        M_GNT = 1'b0;
   logic        M_RVALID = 1'b0;
   logic [31:0] M_RDATA = 32'h0;
   logic        TIMEOUT_ERR;

   int n_assert = 0;
   int n_fail   = 0;

   mem_arbiter #(.STARVE_LIMIT(2), .TIMEOUT_CYCLES(8)) dut (
      .CLK(CLK), .RST(RST),
      .I_RDEN(I_RDEN), .I_RADDR(I_RADDR), .I_RVALID(I_RVALID), .I_ROADDR(I_ROADDR), .I_RDATA(I_RDATA),
      .D_RDEN(D_RDEN), .D_RADDR(D_RADDR), .D_RVALID(D_RVALID), .D_ROADDR(D_ROADDR), .D_RDATA(D_RDATA),
      .D_WREN(D_WREN), .D_WADDR(D_WADDR), .D_WSTRB(D_WSTRB), .D_WDATA(D_WDATA), .D_WDONE(D_WDONE),
      .MEM_WAIT(MEM_WAIT), .M_REQ(M_REQ), .M_WE(M_WE), .M_ADDR(M_ADDR), .M_STRB(M_STRB),
      .M_WDATA(M_WDATA), .M_GNT(M_GNT), .M_RVALID(M_RVALID), .M_RDATA(M_RDATA),
      .TIMEOUT_ERR(TIMEOUT_ERR)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #2;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: observed running expected finished");
      $fatal(1, "bench timeout");
   end

   initial begin
      logic [31:0] grants [6];
      logic [31:0] exp3   [6];
      int ng;
      int ni;
      int nd;
      int bad;
      exp3 = '{32'h3000, 32'h3000, 32'h200, 32'h3000, 32'h3000, 32'h200};

      // Reset state
      tick();
      chk("rst_m_req", M_REQ, 32'd0);
      chk("rst_mem_wait", MEM_WAIT, 32'd0);
      chk("rst_m_addr", M_ADDR, 32'd0);
      chk("rst_i_rvalid", I_RVALID, 32'd0);
      chk("rst_timeout", TIMEOUT_ERR, 32'd0);
      RST = 1'b1;
      tick();

      // 1: single inst read
      I_RDEN = 1'b1; I_RADDR = 32'h100;
      #1 chk("t1_wait_c0", MEM_WAIT, 32'd0);
      tick();
      chk("t1_m_req", M_REQ, 32'd1);
      chk("t1_m_we", M_WE, 32'd0);
      chk("t1_m_addr", M_ADDR, 32'h100);
      chk("t1_m_strb", M_STRB, 32'hF);
      chk("t1_wait_req", MEM_WAIT, 32'd1);
      M_GNT = 1'b1;
      tick();
      chk("t1_req_drop", M_REQ, 32'd0);
      M_GNT = 1'b0;
      tick();
      M_RVALID = 1'b1; M_RDATA = 32'h13;
      tick();
      chk("t1_i_rvalid", I_RVALID, 32'd1);
      chk("t1_i_roaddr", I_ROADDR, 32'h100);
      chk("t1_i_rdata", I_RDATA, 32'h13);
      chk("t1_d_rvalid", D_RVALID, 32'd0);
      M_RVALID = 1'b0; I_RDEN = 1'b0;
      #1 chk("t1_wait_idle", MEM_WAIT, 32'd0);
      tick();
      chk("t1_pulse_end", I_RVALID, 32'd0);
      chk("t1_no_rereq", M_REQ, 32'd0);

      // 2: write beats a simultaneous inst read
      D_WREN = 1'b1; D_WADDR = 32'h2000; D_WDATA = 32'hA5A5A5A5; D_WSTRB = 4'hF;
      I_RDEN = 1'b1; I_RADDR = 32'h104;
      #1 chk("t2_wait_c0", MEM_WAIT, 32'd1);
      tick();
      chk("t2_m_we", M_WE, 32'd1);
      chk("t2_m_addr", M_ADDR, 32'h2000);
      chk("t2_m_wdata", M_WDATA, 32'hA5A5A5A5);
      chk("t2_m_strb", M_STRB, 32'hF);
      chk("t2_wait_req", MEM_WAIT, 32'd1);
      M_GNT = 1'b1;
      tick();
      chk("t2_wdone", D_WDONE, 32'd1);
      chk("t2_req_drop", M_REQ, 32'd0);
      D_WREN = 1'b0; M_GNT = 1'b0;
      tick();
      chk("t2_wdone_end", D_WDONE, 32'd0);
      chk("t2_i_m_req", M_REQ, 32'd1);
      chk("t2_i_m_we", M_WE, 32'd0);
      chk("t2_i_m_addr", M_ADDR, 32'h104);
      chk("t2_i_wait", MEM_WAIT, 32'd1);
      M_GNT = 1'b1;
      tick();
      M_GNT = 1'b0; M_RVALID = 1'b1; M_RDATA = 32'hDEADBEEF;
      chk("t2_wait_resp", MEM_WAIT, 32'd1);
      tick();
      chk("t2_i_rvalid", I_RVALID, 32'd1);
      chk("t2_i_roaddr", I_ROADDR, 32'h104);
      chk("t2_i_rdata", I_RDATA, 32'hDEADBEEF);
      I_RDEN = 1'b0; M_RVALID = 1'b0;
      tick();

      // 3: anti-starvation with STARVE_LIMIT=2
      D_RDEN = 1'b1; D_RADDR = 32'h3000; I_RDEN = 1'b1; I_RADDR = 32'h200;
      M_GNT = 1'b1; M_RVALID = 1'b1; M_RDATA = 32'h55;
      ng = 0; ni = 0; nd = 0;
      for (int c = 1; c <= 18; c++) begin
         tick();
         if (M_REQ) begin
            if (ng < 6) grants[ng] = M_ADDR;
            ng++;
         end
         if (I_RVALID) ni++;
         if (D_RVALID) nd++;
      end
      D_RDEN = 1'b0; I_RDEN = 1'b0; M_GNT = 1'b0; M_RVALID = 1'b0;
      chk("t3_grant_count", ng, 32'd6);
      for (int k = 0; k < 6; k++) begin
         if (k < ng) chk($sformatf("t3_grant%0d", k), grants[k], exp3[k]);
      end
      chk("t3_i_pulses", ni, 32'd2);
      chk("t3_d_pulses", nd, 32'd4);
      chk("t3_i_rdata", I_RDATA, 32'h55);
      tick();

      // 4: grant held off for 5 cycles
      D_WREN = 1'b1; D_WADDR = 32'h4000; D_WDATA = 32'h12345678; D_WSTRB = 4'h3;
      tick();
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         if (i == 0) begin
            D_WADDR = 32'hFFFF0000; D_WDATA = 32'h0; D_WSTRB = 4'hC;
         end
         #1;
         if (!(M_REQ === 1'b1 && M_ADDR === 32'h4000 && M_WDATA === 32'h12345678 &&
               M_STRB === 4'h3 && M_WE === 1'b1 && MEM_WAIT === 1'b1 && D_WDONE === 1'b0)) bad++;
         tick();
      end
      chk("t4_stable_cycles_bad", bad, 32'd0);
      chk("t4_req_before_gnt", M_REQ, 32'd1);
      M_GNT = 1'b1;
      tick();
      chk("t4_wdone", D_WDONE, 32'd1);
      chk("t4_req_drop", M_REQ, 32'd0);
      D_WREN = 1'b0; M_GNT = 1'b0;
      tick();
      chk("t4_wdone_end", D_WDONE, 32'd0);

      // Requester drops after winning: transaction still reported
      I_RDEN = 1'b1; I_RADDR = 32'h700;
      tick();
      I_RDEN = 1'b0; M_GNT = 1'b1;
      tick();
      M_GNT = 1'b0; M_RVALID = 1'b1; M_RDATA = 32'hAB;
      tick();
      chk("drop_i_rvalid", I_RVALID, 32'd1);
      chk("drop_i_rdata", I_RDATA, 32'hAB);
      M_RVALID = 1'b0;
      tick();

      // 5a: reset during REQ drops M_REQ asynchronously
      D_RDEN = 1'b1; D_RADDR = 32'h5000;
      tick();
      chk("t5a_req", M_REQ, 32'd1);
      #1 RST = 1'b0; D_RDEN = 1'b0;
      #1 chk("t5a_req_async", M_REQ, 32'd0);
      tick();
      RST = 1'b1;
      tick();

      // 5b: reset during RESP, late response ignored
      D_RDEN = 1'b1; D_RADDR = 32'h5000;
      tick();
      M_GNT = 1'b1;
      tick();
      M_GNT = 1'b0;
      chk("t5b_addr_pre", M_ADDR, 32'h5000);
      RST = 1'b0; D_RDEN = 1'b0;
      #1;
      chk("t5b_m_req", M_REQ, 32'd0);
      chk("t5b_m_addr", M_ADDR, 32'd0);
      chk("t5b_m_strb", M_STRB, 32'd0);
      chk("t5b_i_roaddr", I_ROADDR, 32'd0);
      chk("t5b_i_rdata", I_RDATA, 32'd0);
      chk("t5b_d_roaddr", D_ROADDR, 32'd0);
      chk("t5b_wait", MEM_WAIT, 32'd0);
      tick();
      RST = 1'b1;
      tick();
      M_RVALID = 1'b1; M_RDATA = 32'h99;
      tick();
      chk("t5b_no_d_rvalid", D_RVALID, 32'd0);
      chk("t5b_no_i_rvalid", I_RVALID, 32'd0);
      chk("t5b_d_rdata", D_RDATA, 32'd0);
      M_RVALID = 1'b0;
      tick();

      // 6: response watchdog (or indefinite wait without it)
      D_RDEN = 1'b1; D_RADDR = 32'h6000;
      tick();
      M_GNT = 1'b1;
      tick();
      M_GNT = 1'b0;
      chk("t6_to_first", TIMEOUT_ERR, 32'd0);
`ifdef MEMARB_TIMEOUT_EN
      bad = 0;
      for (int i = 0; i < 7; i++) begin
         tick();
         if (TIMEOUT_ERR !== 1'b0 || D_RVALID !== 1'b0) bad++;
      end
      chk("t6_early_bad", bad, 32'd0);
      tick();
      chk("t6_timeout_err", TIMEOUT_ERR, 32'd1);
      chk("t6_d_rvalid", D_RVALID, 32'd1);
      chk("t6_d_rdata", D_RDATA, 32'd0);
      chk("t6_d_roaddr", D_ROADDR, 32'h6000);
      D_RDEN = 1'b0; M_RVALID = 1'b1; M_RDATA = 32'h77;
      tick();
      M_RVALID = 1'b0;
      chk("t6_late_ignored", D_RVALID, 32'd0);
      chk("t6_to_pulse_end", TIMEOUT_ERR, 32'd0);
`else
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (TIMEOUT_ERR !== 1'b0 || D_RVALID !== 1'b0 || MEM_WAIT !== 1'b1) bad++;
      end
      chk("t6_wait_bad", bad, 32'd0);
      M_RVALID = 1'b1; M_RDATA = 32'h77;
      tick();
      chk("t6_d_rvalid", D_RVALID, 32'd1);
      chk("t6_d_rdata", D_RDATA, 32'h77);
      chk("t6_d_roaddr", D_ROADDR, 32'h6000);
      chk("t6_no_timeout", TIMEOUT_ERR, 32'd0);
      D_RDEN = 1'b0; M_RVALID = 1'b0;
`endif
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares the single MMU memory port between instruction fetch reads, data reads from the load stage and data writes from the store stage. Sits between the core pipeline (fetch/mread/mwrite) and the MMU.
- Runs a 3-state request/response FSM with fixed priority: write > data read > inst read.
- An anti-starvation counter guarantees fetch progress.
- Drives MEM_WAIT back to the core as the pipeline stall.

Parameters:
STARVE_LIMIT, 4, consecutive data grants allowed while I_RDEN pending before inst is forced to win (1..255)
TIMEOUT_CYCLES, 255, response watchdog limit, used only with MEMARB_TIMEOUT_EN (1..255)

Ports:
CLK  in  1  clock
RST  in  1  reset; one clock, reset asynchronous and active-low
I_RDEN  in  1  inst read request, held until I_RVALID
I_RADDR  in  32  inst read address
I_RVALID  out  1  inst read data valid, 1-cycle pulse
I_ROADDR  out  32  address belonging to I_RDATA
I_RDATA  out  32  inst read data
D_RDEN  in  1  data read request, held until D_RVALID
D_RADDR  in  32  data read address
D_RVALID  out  1  data read valid, 1-cycle pulse
D_ROADDR  out  32  address belonging to D_RDATA
D_RDATA  out  32  data read data
D_WREN  in  1  data write request, held until D_WDONE
D_WADDR  in  32  write address
D_WSTRB  in  4  byte strobes
D_WDATA  in  32  write data
D_WDONE  out  1  write accepted, 1-cycle pulse
MEM_WAIT  out  1  stall to core
M_REQ  out  1  memory request
M_WE  out  1  1=write, 0=read
M_ADDR  out  32  memory address
M_STRB  out  4  strobes (4'hF on reads)
M_WDATA  out  32  write data
M_GNT  in  1  memory accepts request this cycle
M_RVALID  in  1  read response valid
M_RDATA  in  32  read response data
TIMEOUT_ERR  out  1  watchdog pulse (tied 0 without MEMARB_TIMEOUT_EN)

Behaviour:
- Reset (RST=0, async): state IDLE, starve counter 0, all registered outputs and latched owner/addr/data/strb 0. M_REQ drops immediately, including mid-transaction.
- MEM_WAIT is combinational: (state!=IDLE) | (two or more of I_RDEN/D_RDEN/D_WREN high).
- IDLE:
  - If any request is high, pick a winner.
  - Latch owner, M_WE, M_ADDR, M_STRB, M_WDATA (all registered), set M_REQ=1 and go to REQ.
  - Winner order: D_WREN, then D_RDEN, then I_RDEN.
  - Exception: if I_RDEN=1 and starve counter==STARVE_LIMIT, inst wins.
- REQ:
  - M_REQ and all M_* outputs stay stable until M_GNT=1.
  - On grant, M_REQ drops next edge.
  - Write: D_WDONE pulses the following cycle and the FSM returns to IDLE.
  - Read: go to RESP.
- RESP:
  - On M_RVALID=1, register M_RDATA and the latched address to the owner's RDATA/ROADDR.
  - Pulse the owner's RVALID for 1 cycle, return to IDLE.
  - M_RVALID outside RESP is ignored.
- Latency:
  - Request seen in IDLE at cycle 0 produces M_REQ at cycle 1.
  - With M_GNT at cycle 1, D_WDONE is high at cycle 2.
  - M_RVALID at cycle k produces owner RVALID at k+1.
  - Back-to-back requests: minimum 1 IDLE cycle between transactions.
- Starve counter (8 bit):
  - Increments on each data grant while I_RDEN=1.
  - Clears on an inst grant, or in any cycle with I_RDEN=0.
  - Saturates at STARVE_LIMIT.
- Simultaneous D_WREN and D_RDEN: write is served first; this preserves program order for the same address.
- A requester dropping its request after it has won has no effect; the transaction completes and is reported.
- Unused owner outputs keep their last value; only the pulses distinguish owners.

Optional Feature:
MEMARB_TIMEOUT_EN:
- Defined: an 8-bit watchdog counts cycles in RESP.
- When it reaches TIMEOUT_CYCLES without M_RVALID:
  - TIMEOUT_ERR pulses 1 cycle.
  - The owner's RVALID pulses with RDATA=32'h0.
  - The FSM returns to IDLE.
  - A late M_RVALID is ignored.
- Undefined: no counter, TIMEOUT_ERR tied 0, RESP waits indefinitely.

Test Plan:
1. I_RDEN=1, I_RADDR=0x100; M_GNT at cycle 1; M_RVALID with 0x00000013 at cycle 3 -> M_REQ=1, M_WE=0, M_ADDR=0x100 at cycle 1; I_RVALID=1, I_ROADDR=0x100, I_RDATA=0x13 at cycle 4; MEM_WAIT=0 once IDLE.
2. Same cycle: D_WREN (0x2000, 0xA5A5A5A5, strb 0xF) and I_RDEN (0x104) -> write issued first (M_WE=1, M_STRB=0xF), D_WDONE pulse, then inst read at 0x104; MEM_WAIT=1 throughout.
3. STARVE_LIMIT=2, D_RDEN held continuously with immediate M_GNT/M_RVALID, I_RDEN held -> grants D, D, I, D, D, I.
4. M_GNT low for 5 cycles after M_REQ -> M_REQ/M_ADDR/M_WDATA unchanged all 5 cycles, MEM_WAIT=1; grant on 6th completes normally.
5. RST low while in RESP, M_RVALID arrives after release -> M_REQ=0 immediately; no I_RVALID/D_RVALID pulse; all outputs 0.
6. (MEMARB_TIMEOUT_EN, TIMEOUT_CYCLES=8) data read granted, no M_RVALID -> after 8 RESP cycles TIMEOUT_ERR=1 and D_RVALID=1 with D_RDATA=0; later M_RVALID ignored.
